enc_bank_scheduler: RTL and testbench

Schedules code blocks from code-block segmentation (CBS) into the single turbo encoder core through a two-bank (ping-pong) input buffer. CBS fills one bank while the encoder drains the other. The block tracks bank occupancy and per-bank block size. It issues a one-cycle start, with bank select and length, to the encoder FSM, then waits for completion before releasing the bank. It sits between the CBS output handshake and the encoder FSM's cbs_ready/ready inputs.

---
 rtl/enc_pkg.sv | 28 ++
 rtl/enc_bank_tracker.sv | 57 +++++
 rtl/enc_bank_scheduler.sv | 114 +++++++++++
 tb/tb_enc_bank_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, size codes and scheduler state encoding for the
// turbo-encoder ping-pong bank scheduler.
package enc_pkg;

  localparam int unsigned K_SMALL     = 1056;
  localparam int unsigned K_LARGE     = 6144;
  localparam int unsigned LEN_W       = 13;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned TMR_W       = $clog2(ACK_TIMEOUT + 1);

  localparam logic SIZE_SMALL = 1'b0;
  localparam logic SIZE_LARGE = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    RELEASE  = 3'd4
  } sched_state_t;

  // Block length in bits for a size code.
  function automatic logic [LEN_W-1:0] size_to_len(input logic size);
    return (size == SIZE_LARGE) ? LEN_W'(K_LARGE) : LEN_W'(K_SMALL);
  endfunction

endpackage

// File: rtl/enc_bank_tracker.sv
// Ping-pong bank bookkeeping: write/read pointers, occupancy flags,
// per-bank size codes and the sticky overflow flag.
module enc_bank_tracker
  import enc_pkg::*;
(
  input  logic       clock,
  input  logic       aclr,
  input  logic       wr_done,
  input  logic       wr_size,
  input  logic       rel,
  output logic       wr_bank,
  output logic       wr_ready,
  output logic       rd_ptr,
  output logic [1:0] bank_full,
  output logic       rd_full_c,
  output logic       rd_size_c,
  output logic       err_ovf
);

  logic [1:0] size_q;
  logic [1:0] full_next;
  logic       accept_c;
  logic       wr_ptr_next;
  logic       rd_ptr_next;

  assign accept_c    = wr_done & wr_ready;
  assign rd_full_c   = bank_full[rd_ptr];
  assign rd_size_c   = size_q[rd_ptr];
  assign wr_ptr_next = wr_bank ^ accept_c;
  assign rd_ptr_next = rd_ptr ^ rel;

  // A write and a release always target different banks, so both apply.
  always_comb begin
    full_next = bank_full;
    if (accept_c) full_next[wr_bank] = 1'b1;
    if (rel)      full_next[rd_ptr]  = 1'b0;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      bank_full <= 2'b00;
      size_q    <= 2'b00;
      wr_bank   <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ready  <= 1'b1;
      err_ovf   <= 1'b0;
    end else begin
      bank_full <= full_next;
      wr_bank   <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      wr_ready  <= ~full_next[wr_ptr_next];
      if (accept_c) size_q[wr_bank] <= wr_size;
      if (wr_done && !wr_ready) err_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/enc_bank_scheduler.sv
// Issues code blocks from the two-bank input buffer to the turbo encoder:
// start pulse, ack supervision, completion wait and bank release.
module enc_bank_scheduler
  import enc_pkg::*;
(
  input  logic             clock,
  input  logic             aclr,
  input  logic             wr_done,
  input  logic             wr_size,
  output logic             wr_bank,
  output logic             wr_ready,
  input  logic             enc_ready,
  input  logic             enc_done,
  output logic             enc_start,
  output logic             enc_bank,
  output logic             enc_size,
  output logic [LEN_W-1:0] enc_len,
  output logic [1:0]       bank_full,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_done,
  output logic             err_ovf,
  output logic             err_proto
);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_next;
  logic [CNT_W-1:0] blocks_next;
  logic             err_proto_next;
  logic             rel_c;
  logic             rd_ptr;
  logic             rd_full_c;
  logic             rd_size_c;

  enc_bank_tracker u_tracker (
    .clock     (clock),
    .aclr      (aclr),
    .wr_done   (wr_done),
    .wr_size   (wr_size),
    .rel       (rel_c),
    .wr_bank   (wr_bank),
    .wr_ready  (wr_ready),
    .rd_ptr    (rd_ptr),
    .bank_full (bank_full),
    .rd_full_c (rd_full_c),
    .rd_size_c (rd_size_c),
    .err_ovf   (err_ovf)
  );

  // Next-state, ack timer, completion counter and protocol error.
  always_comb begin
    state_next     = state;
    tmr_next       = tmr;
    blocks_next    = blocks_done;
    err_proto_next = err_proto;
    rel_c          = 1'b0;
    case (state)
      IDLE: begin
        if (rd_full_c && enc_ready) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAIT_ACK;
        tmr_next   = '0;
      end
      WAIT_ACK: begin
        if (!enc_ready) begin
          state_next = RUN;
        end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_next     = ISSUE;
          err_proto_next = 1'b1;
        end else begin
          tmr_next = tmr + TMR_W'(1);
        end
      end
      RUN: begin
        if (enc_done) state_next = RELEASE;
      end
      RELEASE: begin
        rel_c      = 1'b1;
        state_next = IDLE;
        if (blocks_done != {CNT_W{1'b1}}) blocks_next = blocks_done + CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
    if (enc_done && (state != RUN)) err_proto_next = 1'b1;
  end

  // enc_bank/enc_size track the read bank, which cannot move until RELEASE.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state       <= IDLE;
      tmr         <= '0;
      enc_start   <= 1'b0;
      busy        <= 1'b0;
      blocks_done <= '0;
      err_proto   <= 1'b0;
      enc_bank    <= 1'b0;
      enc_size    <= SIZE_SMALL;
      enc_len     <= LEN_W'(K_SMALL);
    end else begin
      state       <= state_next;
      tmr         <= tmr_next;
      enc_start   <= (state_next == ISSUE);
      busy        <= (state_next != IDLE);
      blocks_done <= blocks_next;
      err_proto   <= err_proto_next;
      enc_bank    <= rd_ptr;
      enc_size    <= rd_size_c;
      enc_len     <= size_to_len(rd_size_c);
    end
  end

endmodule

// File: tb/tb_enc_bank_scheduler.sv
// Bench for enc_bank_scheduler: directed per-cycle vector tables, a
// reset-during-RUN sequence, then random traffic against a queue-based model.
module tb_enc_bank_scheduler;
  import enc_pkg::*;

  logic             clock = 1'b0;
  logic             aclr;
  logic             wr_done, wr_size, enc_ready, enc_done;
  logic             wr_bank, wr_ready, enc_start, enc_bank, enc_size, busy;
  logic             err_ovf, err_proto;
  logic [LEN_W-1:0] enc_len;
  logic [1:0]       bank_full;
  logic [CNT_W-1:0] blocks_done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  enc_bank_scheduler dut (
    .clock       (clock),
    .aclr        (aclr),
    .wr_done     (wr_done),
    .wr_size     (wr_size),
    .wr_bank     (wr_bank),
    .wr_ready    (wr_ready),
    .enc_ready   (enc_ready),
    .enc_done    (enc_done),
    .enc_start   (enc_start),
    .enc_bank    (enc_bank),
    .enc_size    (enc_size),
    .enc_len     (enc_len),
    .bank_full   (bank_full),
    .busy        (busy),
    .blocks_done (blocks_done),
    .err_ovf     (err_ovf),
    .err_proto   (err_proto)
  );

  // rst: pulse aclr first; inputs wd ws er ed; expected outputs after the edge
  typedef struct {
    int rst; int wd; int ws; int er; int ed;
    int st; int bz; int bf; int wb; int wr; int blk; int ov; int pr; int eb; int ln;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int bz, input int bf,
                           input int wb, input int wr, input int blk, input int ov,
                           input int pr, input int eb, input int ln);
    chk($sformatf("%s.enc_start", tag),   32'(enc_start),   st);
    chk($sformatf("%s.busy", tag),        32'(busy),        bz);
    chk($sformatf("%s.bank_full", tag),   32'(bank_full),   bf);
    chk($sformatf("%s.wr_bank", tag),     32'(wr_bank),     wb);
    chk($sformatf("%s.wr_ready", tag),    32'(wr_ready),    wr);
    chk($sformatf("%s.blocks_done", tag), 32'(blocks_done), blk);
    chk($sformatf("%s.err_ovf", tag),     32'(err_ovf),     ov);
    chk($sformatf("%s.err_proto", tag),   32'(err_proto),   pr);
    if (st != 0) begin
      chk($sformatf("%s.enc_bank", tag), 32'(enc_bank), eb);
      chk($sformatf("%s.enc_len", tag),  32'(enc_len),  ln);
    end
  endtask

  task automatic check_reset(input string tag);
    check_all(tag, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1056);
    chk($sformatf("%s.enc_len", tag),  32'(enc_len),  1056);
    chk($sformatf("%s.enc_bank", tag), 32'(enc_bank), 0);
    chk($sformatf("%s.enc_size", tag), 32'(enc_size), 0);
  endtask

  task automatic pulse_reset();
    aclr = 1'b1;
    #1;
    aclr = 1'b0;
    #1;
  endtask

  // Reference model: blocks accepted/released counts and a FIFO of size codes.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_RUN = 3, P_REL = 4;
  int m_acc, m_rel, m_ph, m_wcnt, m_blk, m_ovf, m_proto;
  bit m_q[$];

  function automatic void m_reset();
    m_acc = 0; m_rel = 0; m_ph = P_IDLE; m_wcnt = 0; m_blk = 0; m_ovf = 0; m_proto = 0;
    m_q.delete();
  endfunction

  function automatic void m_step(input bit wd, input bit ws, input bit er, input bit ed);
    int occ;
    int nph;
    bit pop;
    occ = m_acc - m_rel;
    nph = m_ph;
    pop = 1'b0;
    if (ed && m_ph != P_RUN) m_proto = 1;
    case (m_ph)
      P_IDLE:  if (occ > 0 && er) nph = P_ISSUE;
      P_ISSUE: begin nph = P_WAIT; m_wcnt = 0; end
      P_WAIT: begin
        if (!er) nph = P_RUN;
        else begin
          m_wcnt++;
          if (m_wcnt == ACK_TIMEOUT) begin nph = P_ISSUE; m_proto = 1; end
        end
      end
      P_RUN:   if (ed) nph = P_REL;
      default: begin pop = 1'b1; nph = P_IDLE; end
    endcase
    if (wd) begin
      if (occ < 2) begin m_acc++; m_q.push_back(ws); end
      else m_ovf = 1;
    end
    if (pop) begin
      m_rel++;
      void'(m_q.pop_front());
      if (m_blk < 65535) m_blk++;
    end
    m_ph = nph;
  endfunction

  task automatic check_model(input string tag);
    int occ, bf, ln;
    occ = m_acc - m_rel;
    if (occ >= 2)      bf = 3;
    else if (occ == 1) bf = (m_rel % 2 == 1) ? 2 : 1;
    else               bf = 0;
    ln = (m_q.size() > 0 && m_q[0]) ? 6144 : 1056;
    check_all(tag, (m_ph == P_ISSUE) ? 1 : 0, (m_ph != P_IDLE) ? 1 : 0, bf, m_acc % 2,
              (occ < 2) ? 1 : 0, m_blk, m_ovf, m_proto, m_rel % 2, ln);
  endtask

  initial begin
    // single block, size 1
    vecs.push_back('{1,1,1,1,0, 0,0,1,1,1,0,0,0,0,1056});
    vecs.push_back('{0,0,0,1,0, 1,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,0,1, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,0,0,1,1,1,0,0,0,6144});
    // ping-pong, sizes 0 then 1, write coinciding with release at the end
    vecs.push_back('{1,1,0,1,0, 0,0,1,1,1,0,0,0,0,1056});
    vecs.push_back('{0,1,1,1,0, 1,1,3,0,0,0,0,0,0,1056});
    vecs.push_back('{0,0,0,0,0, 0,1,3,0,0,0,0,0,0,1056});
    vecs.push_back('{0,0,0,0,0, 0,1,3,0,0,0,0,0,0,1056});
    vecs.push_back('{0,0,0,0,1, 0,1,3,0,0,0,0,0,0,1056});
    vecs.push_back('{0,0,0,1,0, 0,0,2,0,1,1,0,0,0,1056});
    vecs.push_back('{0,0,0,1,0, 1,1,2,0,1,1,0,0,1,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,2,0,1,1,0,0,1,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,2,0,1,1,0,0,1,6144});
    vecs.push_back('{0,0,0,0,1, 0,1,2,0,1,1,0,0,1,6144});
    vecs.push_back('{0,1,0,0,0, 0,0,1,1,1,2,0,0,0,1056});
    vecs.push_back('{0,0,0,1,0, 1,1,1,1,1,2,0,0,0,1056});
    // ack timeout: enc_ready held high after start
    vecs.push_back('{1,1,1,1,0, 0,0,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 1,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,1,1,1,1,0,0,0,0,6144});
    vecs.push_back('{0,0,0,1,0, 1,1,1,1,1,0,0,1,0,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,1,1,1,0,0,1,0,6144});
    vecs.push_back('{0,0,0,0,0, 0,1,1,1,1,0,0,1,0,6144});
    vecs.push_back('{0,0,0,0,1, 0,1,1,1,1,0,0,1,0,6144});
    vecs.push_back('{0,0,0,1,0, 0,0,0,1,1,1,0,1,0,6144});
    // stray done in IDLE
    vecs.push_back('{1,0,0,1,1, 0,0,0,0,1,0,0,1,0,1056});
    vecs.push_back('{0,0,0,1,0, 0,0,0,0,1,0,0,1,0,1056});
    // overflow, then issue and run with both banks full (reset follows)
    vecs.push_back('{1,1,0,0,0, 0,0,1,1,1,0,0,0,0,1056});
    vecs.push_back('{0,1,1,0,0, 0,0,3,0,0,0,0,0,0,1056});
    vecs.push_back('{0,1,0,0,0, 0,0,3,0,0,0,1,0,0,1056});
    vecs.push_back('{0,0,0,1,0, 1,1,3,0,0,0,1,0,0,1056});
    vecs.push_back('{0,0,0,0,0, 0,1,3,0,0,0,1,0,0,1056});
    vecs.push_back('{0,0,0,0,0, 0,1,3,0,0,0,1,0,0,1056});

    aclr = 1'b1;
    wr_done = 1'b0; wr_size = 1'b0; enc_ready = 1'b0; enc_done = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clock);
    aclr = 1'b0;
    @(posedge clock); #1;
    check_reset("post_reset");

    foreach (vecs[i]) begin
      if (vecs[i].rst != 0) pulse_reset();
      wr_done   = 1'(vecs[i].wd);
      wr_size   = 1'(vecs[i].ws);
      enc_ready = 1'(vecs[i].er);
      enc_done  = 1'(vecs[i].ed);
      @(posedge clock); #1;
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].bz, vecs[i].bf, vecs[i].wb,
                vecs[i].wr, vecs[i].blk, vecs[i].ov, vecs[i].pr, vecs[i].eb, vecs[i].ln);
    end

    // aclr while in RUN with both banks full: reset values without a clock edge
    wr_done = 1'b0; enc_ready = 1'b0; enc_done = 1'b0;
    #2 aclr = 1'b1;
    #1 check_reset("midrun_reset");
    aclr = 1'b0;
    wr_done = 1'b1; wr_size = 1'b1;
    @(posedge clock); #1;
    check_all("refill", 0, 0, 1, 1, 1, 0, 0, 0, 0, 1056);
    wr_done = 1'b0;

    // random traffic against the model
    pulse_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_done   = ($urandom_range(0, 2) == 0);
      wr_size   = 1'($urandom_range(0, 1));
      enc_ready = ($urandom_range(0, 9) < 7);
      enc_done  = (m_ph == P_RUN) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
      m_step(wr_done, wr_size, enc_ready, enc_done);
      @(posedge clock); #1;
      check_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
        m_reset();
        check_reset($sformatf("rnd_reset%0d", c));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
